// File: rtl/sw_debounce_pkg.sv
// rtl/sw_debounce_pkg.sv - shared types and constants for the switch debouncer
// Contents:
//   db_state_t     per-bit debounce state (STABLE / COUNT)
//   SW_WIDTH       number of board switches
//   DEBOUNCE_10MS  stable cycles for a 10 ms window at 65 MHz
package sw_debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_t;

    localparam int SW_WIDTH      = 16;
    localparam int DEBOUNCE_10MS = 650000;

endpackage

// File: rtl/sw_debounce_if.sv
// rtl/sw_debounce_if.sv - switch bus between raw board pins and switch consumers
// Signals:
//   sw_in       raw asynchronous switch levels (driven by master)
//   sw          debounced levels
//   sw_rise     1-cycle pulse per bit on accepted 0->1
//   sw_fall     1-cycle pulse per bit on accepted 1->0
//   sw_changed  OR of all rise/fall bits, same cycle
//   sw_valid    high once the post-reset settle window has elapsed
// Modports: master drives sw_in and reads the rest; slave is the debouncer.
interface sw_debounce_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] sw_in;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;
    logic             sw_valid;

    modport master (
        output sw_in,
        input  sw, sw_rise, sw_fall, sw_changed, sw_valid
    );

    modport slave (
        input  sw_in,
        output sw, sw_rise, sw_fall, sw_changed, sw_valid
    );
endinterface

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - synchroniser, debounce FSM and counter for one switch
// Ports:
//   clk65MHz  system clock
//   rst       synchronous active-high reset
//   i_raw     raw asynchronous switch level
//   o_level   debounced level
//   o_rise    registered 1-cycle pulse on accepted 0->1
//   o_fall    registered 1-cycle pulse on accepted 1->0
//   o_accept  combinational: a new level is accepted at the coming edge
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic clk65MHz,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    db_state_t     r_state;
    logic [CW-1:0] r_cnt;

    db_state_t     w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_accept;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            STABLE: begin
                if (r_s2 != r_level) begin
                    // A one-cycle window needs no counting phase at all.
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_nxt = COUNT;
                        w_cnt_nxt   = CW'(1);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            COUNT: begin
                if (r_s2 == r_level) begin
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LAST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_state <= STABLE;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rise  <= w_accept & r_s2;
            r_fall  <= w_accept & ~r_s2;
            if (w_accept) begin
                r_level <= r_s2;
            end
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;
endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - debounced 16-switch bus with edge strobes and settle flag
// Ports:
//   clk65MHz  system clock, 65 MHz
//   rst       synchronous active-high reset
//   sw_bus    slave side of sw_debounce_if (sw_in in; sw, sw_rise, sw_fall,
//             sw_changed, sw_valid out)
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int WIDTH           = SW_WIDTH
) (
    input  logic          clk65MHz,
    input  logic          rst,
    sw_debounce_if.slave  sw_bus
);
    localparam int               SCW         = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_accept;

    logic             r_changed;
    logic             r_valid;
    logic [SCW-1:0]   r_settle;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk65MHz(clk65MHz),
            .rst     (rst),
            .i_raw   (sw_bus.sw_in[i]),
            .o_level (w_level[i]),
            .o_rise  (w_rise[i]),
            .o_fall  (w_fall[i]),
            .o_accept(w_accept[i])
        );
    end

    // sw_changed is registered from the same accept terms that load the
    // per-bit strobes, so it lines up with them exactly.
    // The settle window covers the two synchroniser stages plus one full
    // debounce window, after which sw reflects the sampled inputs.
    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            r_changed <= 1'b0;
            r_valid   <= 1'b0;
            r_settle  <= '0;
        end else begin
            r_changed <= |w_accept;
            if (!r_valid) begin
                if (r_settle == SETTLE_LAST) begin
                    r_valid <= 1'b1;
                end else begin
                    r_settle <= r_settle + SCW'(1);
                end
            end
        end
    end

    assign sw_bus.sw         = w_level;
    assign sw_bus.sw_rise    = w_rise;
    assign sw_bus.sw_fall    = w_fall;
    assign sw_bus.sw_changed = r_changed;
    assign sw_bus.sw_valid   = r_valid;
endmodule
